decoder_n_seq: RTL and testbench
================================

// Module: decoder_n_seq
// PURPOSE
//  Parametrised, registered N-to-NUM_OUT one-hot decoder with valid/ready handshake; successor of the 2-to-4 gate-level decoder.
//  Two modes: DIRECT (decode each accepted input word) and SCAN (self-stepping one-hot walk across outputs, wrap-around).
//  Drives chip-select / row-select fan-out where the consumer may stall; one output register stage.
// PARAMETERS
//  N_IN    2  width of select input inp
//  NUM_OUT 4  number of output lines; 1 < NUM_OUT <= 2**N_IN; inp >= NUM_OUT is out of range
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        asynchronous reset, active-high
//  enable     in   1        DIRECT: 0 -> accepted word decodes to all-zero; SCAN: 0 -> pause
//  scan       in   1        1 requests SCAN mode, 0 requests DIRECT mode
//  inp        in   N_IN     select index (DIRECT) / start index (SCAN entry)
//  in_valid   in   1        inp valid
//  in_ready   out  1        block accepts inp this cycle
//  out        out  NUM_OUT  registered one-hot (or all-zero) result
//  out_valid  out  1        out holds a result
//  out_ready  in   1        consumer takes out this cycle
// BEHAVIOUR
//  Reset (async, immediate): out=0, out_valid=0, scan index cnt=0, state=ST_DIRECT; err_flag=0 when compiled in.
//  slot_free = !out_valid || out_ready. Output handshake = out_valid && out_ready.
//  out/out_valid stay stable while out_valid=1 && out_ready=0.
//  ST_DIRECT:
//   - in_ready = slot_free && !scan (combinational; scan wins over in_valid same cycle).
//   - accept (in_valid && in_ready): next cycle out_valid=1, out = enable ? onehot(inp) : 0; latency 1 cycle.
//   - inp >= NUM_OUT: out = 0 (transaction still completes).
//   - slot_free && !accept: out_valid <= 0.
//   - slot_free && scan && enable: go ST_SCAN; cnt <= (inp<NUM_OUT)?inp:0; out <= onehot(that); out_valid <= 1.
//   - scan && !enable: stay ST_DIRECT, in_ready=0.
//  ST_SCAN:
//   - in_ready = 0; inp/in_valid ignored.
//   - on output handshake (or out_valid=0): if scan && enable: cnt <= (cnt==NUM_OUT-1)?0:cnt+1, out <= onehot(next cnt), out_valid <= 1.
//   - if scan && !enable: out_valid <= 0, cnt held (pause; resumes at cnt+1 when enable returns).
//   - if !scan: out_valid <= 0, go ST_DIRECT (pending word always drains before the mode change).
//  out has at most one bit set at all times; wrap NUM_OUT-1 -> 0 with no gap cycle.
//  Reset mid-transfer: pending out discarded, no further handshake until new accept.
// CONFIGURATION
//  DECODER_N_SEQ_ERR_EN defined: extra port err_flag out 1; registered with out; 1 for a word accepted with inp >= NUM_OUT
//   (DIRECT) or SCAN entry with out-of-range start; cleared on next load; 0 in all other cases.
//  Not defined: port absent; out-of-range handled silently as above.
// STRUCTURE
//  Package decoder_n_seq_pkg: state enum {ST_DIRECT, ST_SCAN}; function onehot(idx, NUM_OUT) returning 0 if out of range.
//  Sub-module dec_onehot (combinational index -> one-hot, out-of-range -> 0), instanced once on the load-mux output.
//  Top: FSM, cnt register, output register, handshake logic.
// TESTING
//  N_IN=2,NUM_OUT=4: enable=1, inp=00,01,10,11 with out_ready=1 -> out=0001,0010,0100,1000, one cycle after each accept.
//  enable=0, inp=10 accepted -> out=0000, out_valid=1; out_ready=0 for 3 cycles -> out/out_valid held, in_ready=0.
//  scan=1, inp=10, out_ready=1 -> out sequence 0100,1000,0001,0010,0100 on consecutive cycles (wrap); in_ready=0.
//  SCAN, scan->0 with out_ready=0 -> out held until handshake, then out_valid=0, state DIRECT, in_ready=1.
//  N_IN=3,NUM_OUT=5, inp=6 -> out=00000; with DECODER_N_SEQ_ERR_EN err_flag=1; next inp=4 -> out=10000, err_flag=0.
//  rst pulsed mid-SCAN between clock edges -> out=0, out_valid=0 immediately; after release, DIRECT accept of inp=01 -> 0010.

Source files
------------

// File: rtl/decoder_n_seq_pkg.sv
// Shared types and helpers for the sequenced one-hot decoder.
// Holds the mode enum and an index -> one-hot helper (0 when out of range).
package decoder_n_seq_pkg;

  typedef enum logic {
    ST_DIRECT = 1'b0,
    ST_SCAN   = 1'b1
  } state_t;

  // Widest output any instance may ask the helper for.
  localparam int unsigned MAX_OUT = 256;

  function automatic logic [MAX_OUT-1:0] onehot(
    input int unsigned idx,
    input int unsigned num_out
  );
    onehot = '0;
    if (idx < num_out && idx < MAX_OUT)
      onehot = MAX_OUT'(1) << idx;
  endfunction

endpackage

// File: rtl/decoder_n_seq_dec.sv
// Combinational index -> one-hot decoder; out-of-range index gives all-zero.
// Ports: idx (N_IN) select index, oh (NUM_OUT) one-hot result.
module dec_onehot
  import decoder_n_seq_pkg::*;
#(
  parameter int unsigned N_IN    = 2,
  parameter int unsigned NUM_OUT = 4
) (
  input  logic [N_IN-1:0]    idx,
  output logic [NUM_OUT-1:0] oh
);

  assign oh = NUM_OUT'(onehot(32'(idx), NUM_OUT));

endmodule

// File: rtl/decoder_n_seq.sv
// Registered N-to-NUM_OUT one-hot decoder with DIRECT and SCAN modes.
// Ports: clk, rst (async high), enable, scan, inp, in_valid/in_ready,
// out, out_valid/out_ready; err_flag when DECODER_N_SEQ_ERR_EN is defined.
module decoder_n_seq
  import decoder_n_seq_pkg::*;
#(
  parameter int unsigned N_IN    = 2,
  parameter int unsigned NUM_OUT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               scan,
  input  logic [N_IN-1:0]    inp,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [NUM_OUT-1:0] out,
  output logic               out_valid,
  input  logic               out_ready
`ifdef DECODER_N_SEQ_ERR_EN
  ,
  output logic               err_flag
`endif
);

  localparam logic [N_IN-1:0] LAST = N_IN'(NUM_OUT - 1);

  state_t               state, state_nxt;
  logic [N_IN-1:0]      cnt, cnt_nxt;
  logic [N_IN-1:0]      load_idx;
  logic [NUM_OUT-1:0]   dec;
  logic                 slot_free;
  logic                 inp_ok;
  logic                 load;
  logic                 load_zero;

  assign slot_free = !out_valid || out_ready;
  assign inp_ok    = 32'(inp) < NUM_OUT;
  assign in_ready  = (state == ST_DIRECT) && slot_free && !scan;

  dec_onehot #(
    .N_IN    (N_IN),
    .NUM_OUT (NUM_OUT)
  ) u_dec (
    .idx (load_idx),
    .oh  (dec)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    load_zero = 1'b0;
    load_idx  = inp;
    if (slot_free) begin
      case (state)
        ST_DIRECT: begin
          // scan request takes priority over a waiting input word
          if (scan) begin
            if (enable) begin
              state_nxt = ST_SCAN;
              load      = 1'b1;
              load_idx  = inp_ok ? inp : '0;
              cnt_nxt   = load_idx;
            end
          end else if (in_valid) begin
            load      = 1'b1;
            load_zero = !enable;
          end
        end
        ST_SCAN: begin
          if (!scan) begin
            state_nxt = ST_DIRECT;
          end else if (enable) begin
            load     = 1'b1;
            load_idx = (cnt == LAST) ? '0 : cnt + N_IN'(1);
            cnt_nxt  = load_idx;
          end
        end
        default: state_nxt = ST_DIRECT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_DIRECT;
      cnt       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (slot_free) begin
        out_valid <= load;
        out       <= (load && !load_zero) ? dec : '0;
      end
    end
  end

`ifdef DECODER_N_SEQ_ERR_EN
  // Every load made from DIRECT uses inp, so only those can be out of range.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_flag <= 1'b0;
    else if (slot_free)
      err_flag <= load && (state == ST_DIRECT) && !inp_ok;
  end
`endif

endmodule

// File: tb/tb_decoder_n_seq.sv
// Scoreboard bench for decoder_n_seq (N_IN=3, NUM_OUT=5).
// Directed mode walks plus randomized traffic against a queue-based model.
module tb_decoder_n_seq;

  localparam int N_IN    = 3;
  localparam int NUM_OUT = 5;

  typedef struct {
    logic [NUM_OUT-1:0] o;
    logic               e;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               enable = 1'b0;
  logic               scan = 1'b0;
  logic [N_IN-1:0]    inp = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [NUM_OUT-1:0] out;
  logic               out_valid;
  logic               out_ready = 1'b0;
`ifdef DECODER_N_SEQ_ERR_EN
  logic               err_flag;
`endif

  int total = 0;
  int bad = 0;

  exp_t q[$];
  bit   m_valid = 0;
  bit   m_scan = 0;
  int   m_idx = 0;

  always #5 clk = ~clk;

  decoder_n_seq #(
    .N_IN    (N_IN),
    .NUM_OUT (NUM_OUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .scan      (scan),
    .inp       (inp),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef DECODER_N_SEQ_ERR_EN
    ,
    .err_flag  (err_flag)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: idx < 0 means an all-zero result.
  task automatic push(input int idx, input bit e);
    exp_t x;
    x.o = '0;
    if (idx >= 0) x.o = NUM_OUT'(1) << idx;
    x.e = e;
    q.push_back(x);
    m_valid = 1;
  endtask

  task automatic model_edge(input bit en, input bit sc, input int d,
                            input bit iv, input bit ordy);
    if (!m_valid || ordy) begin
      m_valid = 0;
      if (!m_scan) begin
        if (sc) begin
          if (en) begin
            m_scan = 1;
            m_idx  = (d < NUM_OUT) ? d : 0;
            push(m_idx, d >= NUM_OUT);
          end
        end else if (iv) begin
          push((en && d < NUM_OUT) ? d : -1, d >= NUM_OUT);
        end
      end else if (!sc) begin
        m_scan = 0;
      end else if (en) begin
        m_idx = (m_idx + 1) % NUM_OUT;
        push(m_idx, 1'b0);
      end
    end
  endtask

  task automatic model_reset();
    m_valid = 0;
    m_scan  = 0;
    m_idx   = 0;
    q.delete();
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic step(input bit en, input bit sc, input int d,
                      input bit iv, input bit ordy);
    enable    = en;
    scan      = sc;
    inp       = N_IN'(d);
    in_valid  = iv;
    out_ready = ordy;
    #1;
    chk("in_ready", 32'(in_ready), 32'(!m_scan && (!m_valid || ordy) && !sc));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    model_edge(en, sc, d, iv, ordy);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL mon_unexpected: got out=%0h with empty queue", out);
      end else begin
        chk("out", 32'(out), 32'(q[0].o));
`ifdef DECODER_N_SEQ_ERR_EN
        chk("err_flag", 32'(err_flag), 32'(q[0].e));
`endif
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    bit sc_r;
    @(posedge clk);
    #1;
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    model_reset();

    for (int i = 0; i < NUM_OUT; i++) step(1, 0, i, 1, 1);
    step(1, 0, 0, 0, 1);

    step(0, 0, 2, 1, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 1, 0);
    step(1, 0, 1, 0, 1);

    step(1, 0, 6, 1, 1);
    step(1, 0, 4, 1, 1);
    step(1, 0, 0, 0, 1);

    for (int i = 0; i < 6; i++) step(1, 1, 2, 1, 1);
    step(0, 1, 0, 1, 1);
    step(0, 1, 0, 1, 1);
    step(1, 1, 0, 1, 1);
    step(1, 1, 0, 1, 1);
    step(1, 1, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);

    for (int i = 0; i < 4; i++) step(1, 1, 7, 0, 1);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);

    for (int i = 0; i < 3; i++) step(1, 1, 3, 0, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out", 32'(out), 32'd0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    scan = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1, 0, 1, 1, 1);
    step(1, 0, 0, 0, 1);

    sc_r = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 11) == 0) sc_r = !sc_r;
      step($urandom_range(0, 4) != 0, sc_r, $urandom_range(0, 7),
           $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0);
    end

    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1);
    chk("drain", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
